ledsd_ctrl: RTL
===============

# ledsd_ctrl

Register-mapped controller for the direct-drive seven-segment display path. Holds an 8-entry character buffer plus per-digit enable, decimal-point and blink masks. Sequences blinking and horizontal scrolling from a shared prescaler tick, and drives the parallel `data_in`/`dig`/`dp` inputs of the hex-to-segment decoder. Sits on the peripheral bus as a simple single-cycle write / one-cycle-latency read slave.

## Interface
Parameters:
- `NUM`, 2: number of digits driven; 1..`BUF_DEPTH`.
- `E_CODE`, 1: 1 = 5-bit extended character codes, 0 = 4-bit hex codes.
- `BUF_DEPTH`, 8: character buffer entries; fixed power of two.
- `TICK_DIV`, 6_000_000: clock cycles per prescaler tick; ≥ 2.

Ports:
- `clk`  in  1  single clock for all logic.
- `rst_n`  in  1  reset; one clock, reset asynchronous active-low.
- `wen`  in  1  write strobe, one cycle per write.
- `ren`  in  1  read strobe.
- `addr`  in  4  register address.
- `wdata`  in  8  write data.
- `rdata`  out  8  read data, valid the cycle after `ren`.
- `data_out`  out  [4+E_CODE-1:0] × NUM  character code per digit.
- `dig_out`  out  1 × NUM  digit on, active-high.
- `dp_out`  out  1 × NUM  decimal point on, active-high.

## Operation
- Register map; unmapped writes are ignored, unmapped reads return 0:
  - 0x0 CTRL, rw, reset 0. bit0 `en`, bit1 `blink_en`, bit2 `scroll_en`.
  - 0x1 DIG_EN, rw, mask [NUM-1:0], reset all 1.
  - 0x2 DP, rw, reset 0.
  - 0x3 BLINK, rw, reset 0.
  - 0x4 STATUS, ro. bit0 blink phase, bits[6:4] scroll pointer `ptr`.
  - 0x8–0xF BUF[0..7], rw, reset 0. Only the low 4+E_CODE bits are stored; upper bits read 0.
- Prescaler: counter 0..`TICK_DIV`-1. `tick` pulses for one cycle when the counter equals `TICK_DIV`-1, then wraps to 0.
- Blink phase: toggles on each tick while `blink_en`=1. Held at 0 while `blink_en`=0.
- Scroll pointer `ptr`: increments on each tick while `scroll_en`=1. Wraps from `BUF_DEPTH`-1 to 0. Clearing `scroll_en` freezes `ptr` and does not reset it.
- Any write to CTRL clears the prescaler counter and the blink phase in the same edge.
- Digit i mapping:
  - `data_out[i]` = BUF[(ptr+i) mod BUF_DEPTH].
  - `dp_out[i]` = `en` & DP[i].
  - `dig_out[i]` = `en` & DIG_EN[i] & ~(`blink_en` & BLINK[i] & phase).
- `en`=0 forces `dig_out` and `dp_out` to 0. `data_out` still follows the buffer.
- `wen` and `ren` in the same cycle to the same address: the read returns the pre-write value.
- A tick coinciding with a CTRL write: the write wins. The counter clears and `ptr` does not advance.

## Timing
- All outputs are registered.
- Reset values: `rdata`=0, `data_out`=0, `dig_out`=0, `dp_out`=0, `ptr`=0, phase=0, counter=0.
- Write latency: register updates at the `wen` edge; display outputs reflect it one edge later (2 edges after `wen` sampled).
- Read latency: `rdata` is valid the cycle after `ren`. It holds its value until the next `ren`.
- Tick to display: `ptr`/phase update on the tick edge; outputs follow one cycle later.
- Reset asserted mid-operation: everything returns immediately (asynchronously) to its reset values, including the buffer.

## Structure
- Package `ledsd_ctrl_pkg` holds:
  - Address localparams `ADDR_CTRL`, `ADDR_DIG_EN`, `ADDR_DP`, `ADDR_BLINK`, `ADDR_STATUS`, `ADDR_BUF_BASE`.
  - CTRL bit indices `CTRL_EN`, `CTRL_BLINK`, `CTRL_SCROLL`.
  - Typedef `ctrl_t` as a packed struct of the three CTRL bits.
- One sub-module, `ledsd_tick_gen`: a parameterised prescaler with a synchronous `clr` input and a `tick` output.
- Register file, pointer/phase logic and output mapping live in the top.

## Test plan
Bench uses NUM=2, E_CODE=1, TICK_DIV=4.
- Reset state: release reset → `dig_out`=0, `dp_out`=0, `data_out`=0; reads of 0x1 → 0x03 and of 0x0 → 0x00.
- Static display:
  - Stimulus: write BUF[0]=0x0A, BUF[1]=0x10, DP=0x02, CTRL=0x01.
  - Response: `data_out`={0x10,0x0A}, `dig_out`=2'b11, `dp_out`=2'b10, two edges after the last write.
- Blink:
  - Stimulus: BLINK=0x01, CTRL=0x03.
  - Response: `dig_out[0]` toggles every 4 cycles; `dig_out[1]` stays 1; STATUS bit0 tracks the phase.
- Scroll wrap:
  - Stimulus: BUF[k]=k, CTRL=0x05, run 9 ticks.
  - Response: `data_out[0]` steps 0,1,…,7,0,1; `data_out[1]` is always (`data_out[0]`+1) mod 8.
- Collisions:
  - Same-cycle `wen`/`ren` on 0x8 (old value 0x03, new 0x15): `rdata`=0x03; a following read returns 0x15.
  - CTRL write on a tick cycle: `ptr` unchanged.
- Masking and mid-run reset:
  - `en`=0 with DIG_EN=0x3: `dig_out`=0 while `data_out` still updates.
  - `rst_n` pulsed low mid-scroll: all outputs and `ptr` return to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/ledsd_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ledsd_ctrl_pkg
// Description : Register map, CTRL bit layout and shared types for ledsd_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
package ledsd_ctrl_pkg;

    localparam logic [3:0] ADDR_CTRL     = 4'h0;
    localparam logic [3:0] ADDR_DIG_EN   = 4'h1;
    localparam logic [3:0] ADDR_DP       = 4'h2;
    localparam logic [3:0] ADDR_BLINK    = 4'h3;
    localparam logic [3:0] ADDR_STATUS   = 4'h4;
    localparam logic [3:0] ADDR_BUF_BASE = 4'h8;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_BLINK  = 1;
    localparam int CTRL_SCROLL = 2;

    // Field order mirrors the CTRL register: scroll_en is bit2, en is bit0.
    typedef struct packed {
        logic scroll_en;
        logic blink_en;
        logic en;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/ledsd_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : ledsd_tick_gen
// Description : Free-running prescaler; one-cycle tick every TICK_DIV clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module ledsd_tick_gen #(
    parameter int TICK_DIV = 6_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int              CNT_W   = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_max;

    assign at_max = (cnt_q == CNT_MAX);

    // A clear landing on the terminal count swallows that tick.
    assign tick = at_max && !clr;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr || at_max) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ledsd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ledsd_ctrl
// Description : Register-mapped seven-segment display controller with
//               character buffer, blink and horizontal scroll sequencing.
// Revision    : 1.0 - initial release
// ============================================================================
module ledsd_ctrl
    import ledsd_ctrl_pkg::*;
#(
    parameter int NUM       = 2,
    parameter int E_CODE    = 1,
    parameter int BUF_DEPTH = 8,
    parameter int TICK_DIV  = 6_000_000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wen,
    input  logic                        ren,
    input  logic [3:0]                  addr,
    input  logic [7:0]                  wdata,
    output logic [7:0]                  rdata,
    output logic [NUM*(4+E_CODE)-1:0]   data_out,
    output logic [NUM-1:0]              dig_out,
    output logic [NUM-1:0]              dp_out
);

    localparam int CW    = 4 + E_CODE;
    localparam int PTR_W = $clog2(BUF_DEPTH);

    ctrl_t               ctrl_q,     ctrl_d;
    logic [NUM-1:0]      dig_en_q,   dig_en_d;
    logic [NUM-1:0]      dp_q,       dp_d;
    logic [NUM-1:0]      blink_q,    blink_d;
    logic [CW-1:0]       buf_q [BUF_DEPTH];
    logic [CW-1:0]       buf_d [BUF_DEPTH];
    logic [PTR_W-1:0]    ptr_q,      ptr_d;
    logic                phase_q,    phase_d;
    logic [7:0]          rdata_q,    rdata_d;
    logic [NUM*CW-1:0]   data_out_q, data_out_d;
    logic [NUM-1:0]      dig_out_q,  dig_out_d;
    logic [NUM-1:0]      dp_out_q,   dp_out_d;

    logic                ctrl_wr;
    logic                buf_hit;
    logic [PTR_W-1:0]    buf_idx;
    logic                tick;
    logic                unused_wdata;

    assign ctrl_wr      = wen && (addr == ADDR_CTRL);
    assign buf_hit      = (addr[3:PTR_W] == ADDR_BUF_BASE[3:PTR_W]);
    assign buf_idx      = addr[PTR_W-1:0];
    assign unused_wdata = &{1'b0, wdata};

    ledsd_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (ctrl_wr),
        .tick  (tick)
    );

    // Register file writes
    always_comb begin
        ctrl_d   = ctrl_q;
        dig_en_d = dig_en_q;
        dp_d     = dp_q;
        blink_d  = blink_q;
        buf_d    = buf_q;
        if (wen) begin
            case (addr)
                ADDR_CTRL: begin
                    ctrl_d.en        = wdata[CTRL_EN];
                    ctrl_d.blink_en  = wdata[CTRL_BLINK];
                    ctrl_d.scroll_en = wdata[CTRL_SCROLL];
                end
                ADDR_DIG_EN: dig_en_d = wdata[NUM-1:0];
                ADDR_DP:     dp_d     = wdata[NUM-1:0];
                ADDR_BLINK:  blink_d  = wdata[NUM-1:0];
                default: begin
                    if (buf_hit) begin
                        buf_d[buf_idx] = wdata[CW-1:0];
                    end
                end
            endcase
        end
    end

    // Blink phase and scroll pointer sequencing
    always_comb begin
        phase_d = phase_q;
        ptr_d   = ptr_q;
        if (ctrl_wr || !ctrl_q.blink_en) begin
            phase_d = 1'b0;
        end else if (tick) begin
            phase_d = ~phase_q;
        end
        if (tick && ctrl_q.scroll_en) begin
            ptr_d = ptr_q + PTR_W'(1);
        end
    end

    // Read mux samples pre-write state, so a colliding write is not visible
    always_comb begin
        rdata_d = rdata_q;
        if (ren) begin
            rdata_d = '0;
            case (addr)
                ADDR_CTRL:   rdata_d = {5'b0, ctrl_q};
                ADDR_DIG_EN: rdata_d = 8'(dig_en_q);
                ADDR_DP:     rdata_d = 8'(dp_q);
                ADDR_BLINK:  rdata_d = 8'(blink_q);
                ADDR_STATUS: begin
                    rdata_d[0]          = phase_q;
                    rdata_d[4 +: PTR_W] = ptr_q;
                end
                default: begin
                    if (buf_hit) begin
                        rdata_d = 8'(buf_q[buf_idx]);
                    end
                end
            endcase
        end
    end

    // Per-digit output mapping
    always_comb begin
        data_out_d = '0;
        dig_out_d  = '0;
        dp_out_d   = '0;
        for (int i = 0; i < NUM; i++) begin
            data_out_d[i*CW +: CW] = buf_q[PTR_W'(ptr_q + PTR_W'(i))];
            dp_out_d[i]            = ctrl_q.en & dp_q[i];
            dig_out_d[i]           = ctrl_q.en & dig_en_q[i]
                                   & ~(ctrl_q.blink_en & blink_q[i] & phase_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q     <= '0;
            dig_en_q   <= '1;
            dp_q       <= '0;
            blink_q    <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_q[i] <= '0;
            end
            ptr_q      <= '0;
            phase_q    <= 1'b0;
            rdata_q    <= '0;
            data_out_q <= '0;
            dig_out_q  <= '0;
            dp_out_q   <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            dig_en_q   <= dig_en_d;
            dp_q       <= dp_d;
            blink_q    <= blink_d;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_q[i] <= buf_d[i];
            end
            ptr_q      <= ptr_d;
            phase_q    <= phase_d;
            rdata_q    <= rdata_d;
            data_out_q <= data_out_d;
            dig_out_q  <= dig_out_d;
            dp_out_q   <= dp_out_d;
        end
    end

    assign rdata    = rdata_q;
    assign data_out = data_out_q;
    assign dig_out  = dig_out_q;
    assign dp_out   = dp_out_q;

endmodule
`default_nettype wire
